// File: rtl/rob.sv
`default_nettype none
// ============================================================================
// Module   : rob
// Purpose  : Reorder buffer for the out-of-order RISC-V core. Allocates one
//            entry per issued instruction, captures results broadcast by the
//            reservation station (RS) and load/store buffer (LSB), retires
//            entries in program order and raises a core-wide flush with a
//            redirect PC when a branch or jalr turns out mispredicted.
// Ports    :
//   clk_in, rst_in (async, active high), rdy_in (global enable/freeze)
//   rob_full, tail_id                      - allocation status to decoder
//   to_rob, issue_*                        - issue of one instruction
//   rs_to_rob, rs_dest, rs_value, rs_new_pc- RS write-back
//   lsb_to_rob, lsb_rob_id, lsb_value      - LSB write-back
//   query_{j,k}_id/_ready/_value           - combinational operand lookups
//   commit_reg_en, commit_store, commit_rd, commit_value, commit_rob_id
//                                          - registered retirement outputs
//   clear_all, redirect_pc                 - registered flush pulse + target
// Config   : ROB_BYPASS_EN - when defined, the query ports forward a write-back
//            arriving in the same cycle (RS before LSB).
// Revision : 1.0 - initial release
// ============================================================================
module rob #(
    parameter int ROB_DEPTH  = 8,
    parameter int ROB_ID_BIT = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    output logic                  rob_full,
    output logic [ROB_ID_BIT-1:0] tail_id,
    input  logic                  to_rob,
    input  logic [1:0]            issue_type,
    input  logic [4:0]            issue_rd,
    input  logic                  issue_pred_taken,
    input  logic [31:0]           issue_alt_pc,
    input  logic                  rs_to_rob,
    input  logic [ROB_ID_BIT-1:0] rs_dest,
    input  logic [31:0]           rs_value,
    input  logic [31:0]           rs_new_pc,
    input  logic                  lsb_to_rob,
    input  logic [ROB_ID_BIT-1:0] lsb_rob_id,
    input  logic [31:0]           lsb_value,
    input  logic [ROB_ID_BIT-1:0] query_j_id,
    input  logic [ROB_ID_BIT-1:0] query_k_id,
    output logic                  query_j_ready,
    output logic                  query_k_ready,
    output logic [31:0]           query_j_value,
    output logic [31:0]           query_k_value,
    output logic                  commit_reg_en,
    output logic                  commit_store,
    output logic [4:0]            commit_rd,
    output logic [31:0]           commit_value,
    output logic [ROB_ID_BIT-1:0] commit_rob_id,
    output logic                  clear_all,
    output logic [31:0]           redirect_pc
);

    localparam logic [1:0]            TYPE_REG    = 2'd0;
    localparam logic [1:0]            TYPE_BRANCH = 2'd1;
    localparam logic [1:0]            TYPE_STORE  = 2'd2;
    localparam logic [1:0]            TYPE_JALR   = 2'd3;
    localparam logic [ROB_ID_BIT:0]   FULL_COUNT  = (ROB_ID_BIT+1)'(ROB_DEPTH);
    localparam logic [ROB_ID_BIT:0]   CNT_ONE     = (ROB_ID_BIT+1)'(1);
    localparam logic [ROB_ID_BIT-1:0] ID_ONE      = ROB_ID_BIT'(1);

    // ------------------------------------------------------------------
    // Entry storage and queue pointers
    // ------------------------------------------------------------------
    logic [ROB_DEPTH-1:0]  busy_q,   busy_d;
    logic [ROB_DEPTH-1:0]  ready_q,  ready_d;
    logic [ROB_DEPTH-1:0]  pred_q,   pred_d;
    logic [1:0]            type_q   [ROB_DEPTH];
    logic [1:0]            type_d   [ROB_DEPTH];
    logic [4:0]            rd_q     [ROB_DEPTH];
    logic [4:0]            rd_d     [ROB_DEPTH];
    logic [31:0]           alt_pc_q [ROB_DEPTH];
    logic [31:0]           alt_pc_d [ROB_DEPTH];
    logic [31:0]           value_q  [ROB_DEPTH];
    logic [31:0]           value_d  [ROB_DEPTH];
    logic [31:0]           new_pc_q [ROB_DEPTH];
    logic [31:0]           new_pc_d [ROB_DEPTH];

    logic [ROB_ID_BIT-1:0] head_q,  head_d;
    logic [ROB_ID_BIT-1:0] tail_q,  tail_d;
    logic [ROB_ID_BIT:0]   count_q, count_d;

    // Registered outputs
    logic                  commit_reg_en_q, commit_reg_en_d;
    logic                  commit_store_q,  commit_store_d;
    logic [4:0]            commit_rd_q,     commit_rd_d;
    logic [31:0]           commit_value_q,  commit_value_d;
    logic [ROB_ID_BIT-1:0] commit_rob_id_q, commit_rob_id_d;
    logic                  clear_all_q,     clear_all_d;
    logic [31:0]           redirect_pc_q,   redirect_pc_d;

    logic                  w_commit;
    logic                  w_issue;
    logic                  w_flush;

    // Fullness comes from the registered count only, so a slot freed by a
    // commit this cycle is not handed out until the next cycle.
    assign rob_full = (count_q == FULL_COUNT);
    assign tail_id  = tail_q;
    assign w_issue  = to_rob && !rob_full;
    assign w_commit = (count_q != '0) && busy_q[head_q] && ready_q[head_q];

    // ------------------------------------------------------------------
    // Operand lookups
    // ------------------------------------------------------------------
    always_comb begin
        query_j_ready = busy_q[query_j_id] & ready_q[query_j_id];
        query_j_value = value_q[query_j_id];
        query_k_ready = busy_q[query_k_id] & ready_q[query_k_id];
        query_k_value = value_q[query_k_id];
`ifdef ROB_BYPASS_EN
        // RS is checked last so it wins when both broadcast the same id.
        if (lsb_to_rob && (lsb_rob_id == query_j_id)) begin
            query_j_ready = 1'b1;
            query_j_value = lsb_value;
        end
        if (rs_to_rob && (rs_dest == query_j_id)) begin
            query_j_ready = 1'b1;
            query_j_value = rs_value;
        end
        if (lsb_to_rob && (lsb_rob_id == query_k_id)) begin
            query_k_ready = 1'b1;
            query_k_value = lsb_value;
        end
        if (rs_to_rob && (rs_dest == query_k_id)) begin
            query_k_ready = 1'b1;
            query_k_value = rs_value;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Next-state: commit, flush, write-back, issue
    // ------------------------------------------------------------------
    always_comb begin
        busy_d   = busy_q;
        ready_d  = ready_q;
        pred_d   = pred_q;
        type_d   = type_q;
        rd_d     = rd_q;
        alt_pc_d = alt_pc_q;
        value_d  = value_q;
        new_pc_d = new_pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        commit_reg_en_d = 1'b0;
        commit_store_d  = 1'b0;
        clear_all_d     = 1'b0;
        redirect_pc_d   = '0;
        commit_rd_d     = commit_rd_q;
        commit_value_d  = commit_value_q;
        commit_rob_id_d = commit_rob_id_q;
        w_flush         = 1'b0;

        if (w_commit) begin
            commit_rd_d     = rd_q[head_q];
            commit_value_d  = value_q[head_q];
            commit_rob_id_d = head_q;
            case (type_q[head_q])
                TYPE_REG: begin
                    commit_reg_en_d = (rd_q[head_q] != 5'd0);
                end
                TYPE_STORE: begin
                    commit_store_d = 1'b1;
                end
                TYPE_BRANCH: begin
                    // Resolved direction travels in bit 0 of the result.
                    if (value_q[head_q][0] != pred_q[head_q]) begin
                        w_flush       = 1'b1;
                        redirect_pc_d = alt_pc_q[head_q];
                    end
                end
                default: begin
                    // jalr: value is the link address, alt_pc the predicted target
                    commit_reg_en_d = (rd_q[head_q] != 5'd0);
                    if (new_pc_q[head_q] != alt_pc_q[head_q]) begin
                        w_flush       = 1'b1;
                        redirect_pc_d = new_pc_q[head_q];
                    end
                end
            endcase
        end

        if (w_flush) begin
            // Everything younger than the mispredicted instruction is wrong-path;
            // this cycle's issue and write-backs are dropped with it.
            clear_all_d = 1'b1;
            busy_d      = '0;
            ready_d     = '0;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
        end else begin
            if (lsb_to_rob && busy_q[lsb_rob_id]) begin
                ready_d[lsb_rob_id] = 1'b1;
                value_d[lsb_rob_id] = lsb_value;
            end
            if (rs_to_rob && busy_q[rs_dest]) begin
                ready_d[rs_dest]  = 1'b1;
                value_d[rs_dest]  = rs_value;
                new_pc_d[rs_dest] = rs_new_pc;
            end

            if (w_commit) begin
                busy_d[head_q] = 1'b0;
                head_d         = head_q + ID_ONE;
            end

            // The tail slot is never busy unless the buffer is full, in which
            // case no issue is accepted, so it cannot collide with a write-back.
            if (w_issue) begin
                busy_d[tail_q]   = 1'b1;
                ready_d[tail_q]  = 1'b0;
                type_d[tail_q]   = issue_type;
                rd_d[tail_q]     = issue_rd;
                pred_d[tail_q]   = issue_pred_taken;
                alt_pc_d[tail_q] = issue_alt_pc;
                tail_d           = tail_q + ID_ONE;
            end

            if (w_issue && !w_commit) begin
                count_d = count_q + CNT_ONE;
            end else if (!w_issue && w_commit) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers; rdy_in low freezes everything
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q          <= '0;
            ready_q         <= '0;
            pred_q          <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                type_q[i]   <= '0;
                rd_q[i]     <= '0;
                alt_pc_q[i] <= '0;
                value_q[i]  <= '0;
                new_pc_q[i] <= '0;
            end
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            commit_reg_en_q <= 1'b0;
            commit_store_q  <= 1'b0;
            commit_rd_q     <= '0;
            commit_value_q  <= '0;
            commit_rob_id_q <= '0;
            clear_all_q     <= 1'b0;
            redirect_pc_q   <= '0;
        end else if (rdy_in) begin
            busy_q          <= busy_d;
            ready_q         <= ready_d;
            pred_q          <= pred_d;
            type_q          <= type_d;
            rd_q            <= rd_d;
            alt_pc_q        <= alt_pc_d;
            value_q         <= value_d;
            new_pc_q        <= new_pc_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            commit_reg_en_q <= commit_reg_en_d;
            commit_store_q  <= commit_store_d;
            commit_rd_q     <= commit_rd_d;
            commit_value_q  <= commit_value_d;
            commit_rob_id_q <= commit_rob_id_d;
            clear_all_q     <= clear_all_d;
            redirect_pc_q   <= redirect_pc_d;
        end
    end

    assign commit_reg_en = commit_reg_en_q;
    assign commit_store  = commit_store_q;
    assign commit_rd     = commit_rd_q;
    assign commit_value  = commit_value_q;
    assign commit_rob_id = commit_rob_id_q;
    assign clear_all     = clear_all_q;
    assign redirect_pc   = redirect_pc_q;

endmodule
`default_nettype wire

// File: doc/rob.md
# rob

Reorder buffer for the out-of-order RISC-V core: the receiving end of the result-broadcast interface driven by the reservation station and load/store buffer. Allocates an entry per issued instruction, captures results written back from RS/LSB, retires entries in program order to the register file and store path, and detects branch/jalr mispredictions, issuing a core-wide flush with a redirect PC.

## Interface
Parameters:
- ROB_DEPTH, 8, number of entries (power of two)
- ROB_ID_BIT, 3, log2(ROB_DEPTH); width of every ROB id

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous reset, active high
- rdy_in  input  1  global enable; low freezes all state and outputs
- rob_full  output  1  count == ROB_DEPTH
- tail_id  output  ROB_ID_BIT  id assigned to an instruction issued this cycle
- to_rob  input  1  issue strobe
- issue_type  input  2  0 reg-write, 1 branch, 2 store, 3 jalr
- issue_rd  input  5  destination register (0 = none)
- issue_pred_taken  input  1  branch prediction
- issue_alt_pc  input  32  branch: PC if prediction wrong; jalr: predicted target
- rs_to_rob, rs_dest[ROB_ID_BIT], rs_value[32], rs_new_pc[32]  inputs  RS write-back
- lsb_to_rob, lsb_rob_id[ROB_ID_BIT], lsb_value[32]  inputs  LSB write-back
- query_j_id, query_k_id  input  ROB_ID_BIT  decoder operand lookups
- query_j_ready, query_k_ready  output  1  combinational: entry holds a result
- query_j_value, query_k_value  output  32  combinational result
- commit_reg_en  output  1  registered pulse: write commit_value to commit_rd
- commit_store  output  1  registered pulse: LSB may perform head store
- commit_rd  output  5; commit_value  output  32; commit_rob_id  output  ROB_ID_BIT
- clear_all  output  1  registered one-cycle flush pulse
- redirect_pc  output  32  valid while clear_all high

## Operation
- Per entry: busy, ready, type, rd, pred_taken, alt_pc, value, new_pc. Circular buffer: head, tail, count.
- Issue: to_rob && !rob_full → entry tail allocated (ready=0), tail ← tail+1 mod ROB_DEPTH, count+1. to_rob while rob_full ignored (decoder must not assert).
- Write-back: rs_to_rob sets ready, value, new_pc of entry rs_dest; lsb_to_rob sets ready, value of lsb_rob_id. Both may target different entries the same cycle; writes to non-busy entries ignored.
- Commit, at most one per cycle, when count≠0 and head ready:
  - type 0: commit_reg_en=1 if rd≠0.
  - type 2: commit_store=1.
  - type 1: mispredict if value[0]≠pred_taken → clear_all=1, redirect_pc=alt_pc.
  - type 3: commit_reg_en=1 (rd≠0, value = link); mispredict if new_pc≠alt_pc → clear_all=1, redirect_pc=new_pc.
  - head ← head+1, count−1; commit_rd/value/rob_id driven from head.
- Flush: on the edge registering clear_all, head=tail=count=0, all busy cleared; same-cycle issue and write-backs discarded.
- Simultaneous issue and commit: count unchanged. rob_full derived from registered count (no same-cycle slot reuse).

## Timing
- Reset: all entries free, head=tail=count=0; every output 0 (rob_full 0, redirect_pc 0).
- Write-back at edge E0 → ready at E0; commit outputs registered at E1, visible cycle after E1. Min write-back-to-commit latency 1 cycle.
- Pulses (commit_reg_en, commit_store, clear_all) high exactly one cycle per event, else 0.
- tail_id combinational from registered tail.
- rdy_in low: no state change, outputs hold.
- Async reset mid-flush or mid-commit: immediate return to reset state.

## Configuration
- ROB_BYPASS_EN defined: query ports forward same-cycle rs/lsb write-backs whose id matches (RS priority) — ready=1, value=write-back value.
- Undefined: query ports reflect registered entry state only; write-back visible the next cycle.

## Test plan
- Issue 3 reg-writes (rd 1,2,3), write back ids 2,0,1 values 0x30,0x10,0x20 → commits in order rd1=0x10, rd2=0x20, rd3=0x30, one per cycle.
- Fill 8 entries → rob_full=1, 9th to_rob ignored; commit one → rob_full=0; tail wraps 7→0.
- Branch pred_taken=0, write-back value=1, alt_pc=0x1000, younger entries present → clear_all one cycle, redirect_pc=0x1000, count=0; correctly predicted branch → no flush.
- jalr rd=1, pc link 0x104, new_pc 0x200, alt_pc 0x300 → commit rd1=0x104, clear_all, redirect_pc=0x200.
- Query id during rs_to_rob same id value 0xAB → ready=1/0xAB with ROB_BYPASS_EN, ready=0 without; next cycle ready=1 both.
- Assert rst_in mid-commit and rdy_in low mid-sequence → outputs 0 immediately; freeze holds all outputs.
